// File: rtl/s27_seq_pkg.sv
// Shared types and constants for the s27 vector sequencer.
package s27_seq_pkg;

    // Width of the G-input vector driven into the s27 core (G3..G0).
    localparam int G_W = 4;

    // Width of the settle-timer counter; covers settle lengths 1..15.
    localparam int SETTLE_W = 4;

    // Sequencer states.
    typedef enum logic [2:0] {
        IDLE,
        CORE_RST,
        FETCH,
        SETTLE,
        CAPTURE,
        RESULT,
        FINISH
    } seq_state_t;

    // Low two bits of a result record: observed G17 above expected G17.
    // The full record is {index, res_bits_t}.
    typedef struct packed {
        logic observed;
        logic expected;
    } res_bits_t;

endpackage

// File: rtl/s27_settle_timer.sv
// Load/count-down timer that measures the core settle window.
import s27_seq_pkg::*;

module s27_settle_timer (
    input  logic                clk_net,
    input  logic                reset_net,
    input  logic                load,
    input  logic [SETTLE_W-1:0] load_val,
    input  logic                dec,
    output logic                zero
);

    logic [SETTLE_W-1:0] count_reg;

    // Load takes priority; counting stops at zero so the flag stays asserted.
    always_ff @(posedge clk_net or negedge reset_net) begin
        if (!reset_net) begin
            count_reg <= '0;
        end else if (load) begin
            count_reg <= load_val;
        end else if (dec && (count_reg != '0)) begin
            count_reg <= count_reg - 1'b1;
        end
    end

    assign zero = (count_reg == '0);

endmodule

// File: rtl/s27_vector_sequencer.sv
// Applies stimulus vectors to an s27 core, compares G17 against the
// expected bit and streams one result record per vector.
import s27_seq_pkg::*;

module s27_vector_sequencer #(
    parameter int SETTLE_CYCLES = 2,
    parameter int CNT_W         = 8
) (
    input  logic               clk_net,
    input  logic               reset_net,
    input  logic               start,
    input  logic [CNT_W-1:0]   num_vec,
    input  logic               vec_valid,
    output logic               vec_ready,
    input  logic [G_W-1:0]     vec_data,
    input  logic               vec_expect,
    output logic [G_W-1:0]     core_g,
    output logic               core_reset,
    input  logic               core_g17,
    output logic               res_valid,
    input  logic               res_ready,
    output logic [CNT_W+1:0]   res_data,
    output logic               busy,
    output logic               done,
    output logic [CNT_W-1:0]   mismatch_cnt
);

    // The timer is loaded with N-1 and the FSM leaves SETTLE on the cycle
    // the timer reads zero, giving exactly N cycles in SETTLE.
    localparam logic [SETTLE_W-1:0] SETTLE_LOAD = SETTLE_W'(SETTLE_CYCLES - 1);

    seq_state_t       state_reg;
    logic [CNT_W-1:0] count_reg;
    logic [CNT_W-1:0] index_reg;
    logic             expect_reg;
    logic             settle_zero;
    logic             vec_xfer;
    logic             last_vec;
    res_bits_t        res_bits;

    assign vec_xfer = (state_reg == FETCH) && vec_valid && vec_ready;

    // Widened compare so index+1 cannot wrap when the count is all-ones.
    assign last_vec = !(({1'b0, index_reg} + 1'b1) < {1'b0, count_reg});

    assign res_bits.observed = core_g17;
    assign res_bits.expected = expect_reg;

    s27_settle_timer u_settle_timer (
        .clk_net   (clk_net),
        .reset_net (reset_net),
        .load      (vec_xfer),
        .load_val  (SETTLE_LOAD),
        .dec       (state_reg == SETTLE),
        .zero      (settle_zero)
    );

    // Sequencer FSM; all outputs are registered and set on state entry.
    always_ff @(posedge clk_net or negedge reset_net) begin
        if (!reset_net) begin
            state_reg    <= IDLE;
            count_reg    <= '0;
            index_reg    <= '0;
            expect_reg   <= 1'b0;
            core_g       <= '0;
            core_reset   <= 1'b1;
            vec_ready    <= 1'b0;
            res_valid    <= 1'b0;
            res_data     <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            mismatch_cnt <= '0;
        end else begin
            core_reset <= 1'b0;
            done       <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        count_reg    <= num_vec;
                        index_reg    <= '0;
                        mismatch_cnt <= '0;
                        core_reset   <= 1'b1;
                        busy         <= 1'b1;
                        state_reg    <= CORE_RST;
                    end
                end
                CORE_RST: begin
                    if (count_reg == '0) begin
                        done      <= 1'b1;
                        state_reg <= FINISH;
                    end else begin
                        vec_ready <= 1'b1;
                        state_reg <= FETCH;
                    end
                end
                FETCH: begin
                    if (vec_xfer) begin
                        core_g     <= vec_data;
                        expect_reg <= vec_expect;
                        vec_ready  <= 1'b0;
                        state_reg  <= SETTLE;
                    end
                end
                SETTLE: begin
                    if (settle_zero) begin
                        state_reg <= CAPTURE;
                    end
                end
                CAPTURE: begin
                    if ((core_g17 != expect_reg) && (mismatch_cnt != {CNT_W{1'b1}})) begin
                        mismatch_cnt <= mismatch_cnt + 1'b1;
                    end
                    res_data  <= {index_reg, res_bits};
                    res_valid <= 1'b1;
                    state_reg <= RESULT;
                end
                RESULT: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        index_reg <= index_reg + 1'b1;
                        if (last_vec) begin
                            done      <= 1'b1;
                            state_reg <= FINISH;
                        end else begin
                            vec_ready <= 1'b1;
                            state_reg <= FETCH;
                        end
                    end
                end
                FINISH: begin
                    busy      <= 1'b0;
                    state_reg <= IDLE;
                end
                default: begin
                    busy      <= 1'b0;
                    vec_ready <= 1'b0;
                    res_valid <= 1'b0;
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_s27_vector_sequencer.sv
// Directed, table-driven bench for s27_vector_sequencer with a small
// pipelined stand-in for the s27 core.
module tb_s27_vector_sequencer;

    localparam int CNT_W = 8;

    logic             clk_net = 1'b0;
    logic             reset_net;
    logic             start;
    logic [CNT_W-1:0] num_vec;
    logic             vec_valid;
    logic             vec_ready;
    logic [3:0]       vec_data;
    logic             vec_expect;
    logic [3:0]       core_g;
    logic             core_reset;
    logic             core_g17;
    logic             res_valid;
    logic             res_ready;
    logic [CNT_W+1:0] res_data;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] mismatch_cnt;

    int passed = 0;
    int total  = 0;
    int done_cnt = 0;
    int crst_cnt = 0;
    int vr_cnt   = 0;

    always #5 clk_net = ~clk_net;

    s27_vector_sequencer #(.SETTLE_CYCLES(2), .CNT_W(CNT_W)) dut (
        .clk_net      (clk_net),
        .reset_net    (reset_net),
        .start        (start),
        .num_vec      (num_vec),
        .vec_valid    (vec_valid),
        .vec_ready    (vec_ready),
        .vec_data     (vec_data),
        .vec_expect   (vec_expect),
        .core_g       (core_g),
        .core_reset   (core_reset),
        .core_g17     (core_g17),
        .res_valid    (res_valid),
        .res_ready    (res_ready),
        .res_data     (res_data),
        .busy         (busy),
        .done         (done),
        .mismatch_cnt (mismatch_cnt)
    );

    // Stand-in core: G17 = G3 | (G0 & ~G1), two register stages deep.
    function automatic logic ref_g17(input logic [3:0] g);
        return g[3] | (g[0] & ~g[1]);
    endfunction

    logic [1:0] core_pipe;
    always @(posedge clk_net) begin
        if (core_reset) core_pipe <= 2'b00;
        else            core_pipe <= {core_pipe[0], ref_g17(core_g)};
    end
    assign core_g17 = core_pipe[1];

    // Event counters, sampled at the rising edge (value of the previous cycle).
    always @(posedge clk_net) begin
        if (done) done_cnt++;
        if (core_reset && reset_net) crst_cnt++;
        if (vec_ready) vr_cnt++;
    end

    typedef struct {
        logic [3:0] g;
        logic       obs;
    } vec_t;

    typedef struct {
        int n;
        int first;
        bit inv;
        int hold;
        bit poke;
        int mm;
    } run_t;

    vec_t tbl[4];
    run_t runs[4];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h, required %0h", name, act, exp);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_core_g"}, 32'(core_g), 0);
        check({tag, "_core_reset"}, 32'(core_reset), 1);
        check({tag, "_vec_ready"}, 32'(vec_ready), 0);
        check({tag, "_res_valid"}, 32'(res_valid), 0);
        check({tag, "_busy"}, 32'(busy), 0);
        check({tag, "_done"}, 32'(done), 0);
        check({tag, "_res_data"}, 32'(res_data), 0);
        check({tag, "_mismatch"}, 32'(mismatch_cnt), 0);
    endtask

    // One FETCH transfer plus the matching RESULT handshake.
    task automatic feed_vec(input int k, input logic [3:0] g, input logic e,
                            input logic obs, input int hold, input bit poke);
        int w;
        logic [CNT_W+1:0] snap;
        bit stable;
        w = 0;
        while (!vec_ready && w < 100) begin @(negedge clk_net); w++; end
        check("vec_ready_seen", 32'(vec_ready), 1);
        vec_valid = 1'b1; vec_data = g; vec_expect = e;
        @(negedge clk_net);
        vec_valid = 1'b0;
        check("core_g_loaded", 32'(core_g), 32'(g));
        if (poke) begin
            start = 1'b1; num_vec = CNT_W'(1);
            @(negedge clk_net);
            start = 1'b0;
        end
        w = 0;
        while (!res_valid && w < 100) begin @(negedge clk_net); w++; end
        check("res_valid_seen", 32'(res_valid), 1);
        check("res_index", 32'(res_data[CNT_W+1:2]), 32'(k));
        check("res_observed", 32'(res_data[1]), 32'(obs));
        check("res_expected", 32'(res_data[0]), 32'(e));
        check("res_obs_vs_exp", 32'(res_data[1] ^ res_data[0]), 32'(obs ^ e));
        $display("vec %0d: g=%h expect=%b result=%h mismatches=%0d", k, g, e, res_data, mismatch_cnt);
        if (hold > 0) begin
            snap = res_data;
            stable = 1'b1;
            repeat (hold) begin
                @(negedge clk_net);
                if (!res_valid || (res_data !== snap) || vec_ready) stable = 1'b0;
            end
            check("res_hold_stable", 32'(stable), 1);
        end
        res_ready = 1'b1;
        @(negedge clk_net);
        res_ready = 1'b0;
    endtask

    task automatic do_run(input int n, input int first, input bit inv, input int hold,
                          input bit poke, input int mm);
        logic [3:0] g;
        logic ob;
        int w;
        @(negedge clk_net);
        done_cnt = 0; crst_cnt = 0;
        start = 1'b1; num_vec = CNT_W'(n);
        @(negedge clk_net);
        start = 1'b0;
        for (int k = 0; k < n; k++) begin
            if (first >= 0) begin
                g  = tbl[first + k].g;
                ob = tbl[first + k].obs;
            end else begin
                g  = 4'(k);
                ob = ref_g17(g);
            end
            feed_vec(k, g, ob ^ inv, ob, hold, poke && (k == 0));
        end
        w = 0;
        while (!done && w < 100) begin @(negedge clk_net); w++; end
        check("done_seen", 32'(done), 1);
        @(negedge clk_net);
        @(negedge clk_net);
        check("done_pulses", 32'(done_cnt), 1);
        check("core_reset_cycles", 32'(crst_cnt), 1);
        check("busy_after_run", 32'(busy), 0);
        check("mismatch_cnt", 32'(mismatch_cnt), 32'(mm));
        $display("run n=%0d inv=%0b hold=%0d poke=%0b: mismatches=%0d", n, inv, hold, poke, mismatch_cnt);
    endtask

    initial begin
        int w;
        reset_net = 1'b0; start = 1'b0; num_vec = '0; vec_valid = 1'b0;
        vec_data = 4'h0; vec_expect = 1'b0; res_ready = 1'b0;

        // Hand-computed core responses: G17 = G3 | (G0 & ~G1).
        tbl[0] = '{g: 4'h0, obs: 1'b0};
        tbl[1] = '{g: 4'h5, obs: 1'b1};
        tbl[2] = '{g: 4'hF, obs: 1'b1};
        tbl[3] = '{g: 4'h6, obs: 1'b0};

        runs[0] = '{n: 3, first: 0, inv: 1'b0, hold: 0,  poke: 1'b0, mm: 0};
        runs[1] = '{n: 3, first: 0, inv: 1'b1, hold: 0,  poke: 1'b0, mm: 3};
        runs[2] = '{n: 3, first: 0, inv: 1'b0, hold: 10, poke: 1'b0, mm: 0};
        runs[3] = '{n: 3, first: 0, inv: 1'b0, hold: 0,  poke: 1'b1, mm: 0};

        repeat (3) @(negedge clk_net);
        check_reset_outputs("rst");
        reset_net = 1'b1;
        @(negedge clk_net);
        check("idle_core_reset", 32'(core_reset), 0);
        check("idle_busy", 32'(busy), 0);

        for (int r = 0; r < 4; r++) begin
            do_run(runs[r].n, runs[r].first, runs[r].inv, runs[r].hold, runs[r].poke, runs[r].mm);
        end

        // Empty run: one core_reset cycle, done two cycles after start, no vec_ready.
        @(negedge clk_net);
        done_cnt = 0; crst_cnt = 0; vr_cnt = 0;
        start = 1'b1; num_vec = '0;
        @(negedge clk_net);
        start = 1'b0;
        check("zero_core_reset_c1", 32'(core_reset), 1);
        check("zero_busy_c1", 32'(busy), 1);
        check("zero_done_c1", 32'(done), 0);
        @(negedge clk_net);
        check("zero_core_reset_c2", 32'(core_reset), 0);
        check("zero_done_c2", 32'(done), 1);
        @(negedge clk_net);
        check("zero_done_c3", 32'(done), 0);
        check("zero_busy_c3", 32'(busy), 0);
        check("zero_core_reset_cycles", 32'(crst_cnt), 1);
        check("zero_done_pulses", 32'(done_cnt), 1);
        check("zero_vec_ready_cycles", 32'(vr_cnt), 0);
        $display("run n=0: done pulses=%0d", done_cnt);

        // Reset during SETTLE of vector 1 abandons the run.
        @(negedge clk_net);
        done_cnt = 0;
        start = 1'b1; num_vec = CNT_W'(3);
        @(negedge clk_net);
        start = 1'b0;
        feed_vec(0, 4'h0, 1'b0, 1'b0, 0, 1'b0);
        w = 0;
        while (!vec_ready && w < 100) begin @(negedge clk_net); w++; end
        check("mid_vec_ready_seen", 32'(vec_ready), 1);
        vec_valid = 1'b1; vec_data = 4'h5; vec_expect = 1'b1;
        @(negedge clk_net);
        vec_valid = 1'b0;
        check("mid_busy_in_settle", 32'(busy), 1);
        reset_net = 1'b0;
        #1;
        check_reset_outputs("midrst");
        @(negedge clk_net);
        @(negedge clk_net);
        reset_net = 1'b1;
        repeat (3) @(negedge clk_net);
        check("midrst_no_done", 32'(done_cnt), 0);
        check("midrst_idle_busy", 32'(busy), 0);
        $display("mid-run reset: done pulses=%0d", done_cnt);
        do_run(1, 3, 1'b1, 0, 1'b0, 1);

        // Maximum count, every expect inverted: 255 results, no index wrap.
        do_run(255, -1, 1'b1, 0, 1'b0, 255);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    // Hard stop in case the stimulus itself stalls.
    initial begin
        #2000000;
        $display("FAIL global_timeout: got running, required finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/s27_vector_sequencer.md
S27_VECTOR_SEQUENCER -- requirements
Module: s27_vector_sequencer

Interface
REQ-001 SHALL have parameter SETTLE_CYCLES, default 2: cycles between driving core inputs and sampling core_g17; legal range 1..15.
REQ-002 SHALL have parameter CNT_W, default 8: width of the vector count, index and mismatch count.
REQ-003 SHALL have port clk_net, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset_net, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port start, input, 1 bit: a one-cycle pulse that begins a run.
REQ-006 SHALL have port num_vec, input, CNT_W bits: vectors in the run; sampled on the accepted start.
REQ-007 SHALL have ports vec_valid (input, 1), vec_ready (output, 1), vec_data (input, 4: {G3,G2,G1,G0}) and vec_expect (input, 1: expected G17): the stimulus handshake.
REQ-008 SHALL have port core_g (output, 4): registered drive to core G3..G0.
REQ-009 SHALL have port core_reset (output, 1): active-high reset to the core.
REQ-010 SHALL have port core_g17 (input, 1): the core output.
REQ-011 SHALL have ports res_valid (output, 1), res_ready (input, 1) and res_data (output, CNT_W+2: {index, observed, expected}): the result handshake.
REQ-012 SHALL have port busy (output, 1), done (output, 1: one-cycle pulse) and mismatch_cnt (output, CNT_W).

Function
REQ-013 SHALL use states IDLE, CORE_RST, FETCH, SETTLE, CAPTURE, RESULT and FINISH.
REQ-014 SHALL, in IDLE with start=1, latch num_vec, clear mismatch_cnt and index, and go to CORE_RST; start outside IDLE SHALL be ignored.
REQ-015 SHALL hold core_reset=1 for exactly one cycle in CORE_RST, then go to FETCH, or to FINISH if num_vec=0.
REQ-016 SHALL keep vec_ready=1 only in FETCH; a transfer on vec_valid&vec_ready SHALL load core_g and the expected bit, and go to SETTLE.
REQ-017 SHALL stay in SETTLE for exactly SETTLE_CYCLES cycles, then go to CAPTURE.
REQ-018 SHALL, in CAPTURE, sample core_g17, compare it to the expected bit and increment mismatch_cnt on inequality, saturating at all-ones; then go to RESULT.
REQ-019 SHALL hold res_valid=1 with stable res_data in RESULT until res_ready=1.
REQ-020 SHALL, on the RESULT handshake, increment index and go to FETCH if index+1 < latched count, otherwise to FINISH.
REQ-021 SHALL pulse done=1 for one cycle in FINISH and return to IDLE.
REQ-022 SHALL keep mismatch_cnt valid until the next accepted start.
REQ-023 SHALL hold core_g at its last value outside FETCH transfers; the core's own flops are not reset between vectors.
REQ-024 SHALL assert busy in every state except IDLE.
REQ-025 SHALL tolerate vec_valid=0 in FETCH and res_ready=0 in RESULT indefinitely, with no timeout.
REQ-026 SHALL, with num_vec=2^CNT_W-1, stop after exactly that many results; the index SHALL never wrap within a run.

Reset
REQ-027 SHALL, while reset_net=0, force: state IDLE; core_g=0; core_reset=1; vec_ready, res_valid, busy and done all 0; res_data=0; mismatch_cnt=0.
REQ-028 SHALL, on a mid-run reset, abandon the run with no done pulse; the first start after release SHALL begin a fresh run.

Structure
REQ-029 SHALL place the state enum, the result-record typedef and the G-vector width constant (4) in shared package s27_seq_pkg.
REQ-030 SHALL implement settle timing in one sub-module, s27_settle_timer: load/count-down with a zero flag.

Verification
REQ-031 SHALL cover: num_vec=3, vectors 4'h0, 4'h5, 4'hF, expects matching a reference model -> three results with indexes 0, 1, 2; mismatch_cnt=0; one done pulse.
REQ-032 SHALL cover: the same run with every expect inverted -> mismatch_cnt=3, and each observed bit differs from its expected bit.
REQ-033 SHALL cover: num_vec=0 -> core_reset high for one cycle, done two cycles after start, no vec_ready.
REQ-034 SHALL cover: res_ready held low for 10 cycles -> res_valid and res_data stable throughout and vec_ready low.
REQ-035 SHALL cover: start during SETTLE -> ignored, with the run count unchanged.
REQ-036 SHALL cover: reset_net low during SETTLE of vector 1 -> all outputs at reset values; a later start with num_vec=1 completes normally.
